// File: rtl/pwr_sequencer_if.sv
// Control and status bundle between the motor-power sequencer and its host.
// The master side drives requests and sensor inputs; the slave side is the sequencer.
interface pwr_sequencer_if;
  logic       start;
  logic       stop;
  logic       clear;
  logic [3:0] axis_req;
  logic       mv_good;
  logic       wdog_timeout;
  logic [3:0] safety_amp_disable;
  logic       relay_on;
  logic       pwr_enable;
  logic [3:0] amp_disable;
  logic [2:0] state;
  logic [1:0] err_code;

  modport master (
    output start, stop, clear, axis_req, mv_good, wdog_timeout, safety_amp_disable,
    input  relay_on, pwr_enable, amp_disable, state, err_code
  );

  modport slave (
    input  start, stop, clear, axis_req, mv_good, wdog_timeout, safety_amp_disable,
    output relay_on, pwr_enable, amp_disable, state, err_code
  );
endinterface

// File: rtl/pwr_sequencer.sv
// Motor power sequencer: relay -> motor voltage -> settle -> staggered axis enables,
// with orderly shutdown and latched fault handling. All delays count prescaled ticks.
//
// state   | meaning
// IDLE    | everything off, waiting for start
// RELAY   | safety relay closed, waiting RELAY_TICKS
// WAIT_MV | motor power on, waiting for 8 consecutive good mv_good ticks
// SETTLE  | motor voltage settling for SETTLE_TICKS
// ENABLE  | visiting axes 1..4, one every STAGGER_TICKS
// RUN     | amplifiers follow axis_req
// SHDN    | amps off, power then relay dropped STAGGER_TICKS apart
// FAULT   | everything off, err_code latched until clear
module pwr_sequencer #(
  parameter int PRESCALE_W    = 8,
  parameter int RELAY_TICKS   = 16,
  parameter int MV_TIMEOUT    = 1024,
  parameter int SETTLE_TICKS  = 7680,
  parameter int STAGGER_TICKS = 64
) (
  input  logic            sysclk,
  input  logic            reset,
  pwr_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RELAY   = 3'd1,
    WAIT_MV = 3'd2,
    SETTLE  = 3'd3,
    ENABLE  = 3'd4,
    RUN     = 3'd5,
    SHDN    = 3'd6,
    FAULT   = 3'd7
  } state_t;

  localparam logic [15:0] RELAY_TC    = 16'(RELAY_TICKS);
  localparam logic [15:0] MV_TC       = 16'(MV_TIMEOUT);
  localparam logic [15:0] SETTLE_TC   = 16'(SETTLE_TICKS);
  localparam logic [15:0] STAGGER_TC  = 16'(STAGGER_TICKS);
  localparam logic [15:0] SHDN_END_TC = 16'(2 * STAGGER_TICKS);

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_MV_TO   = 2'b01;
  localparam logic [1:0] ERR_MV_LOST = 2'b10;
  localparam logic [1:0] ERR_WDOG    = 2'b11;

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  tick_q;
  logic [15:0]           cnt_q, cnt_d, cnt_inc;
  logic [2:0]            mv_cnt_q, mv_cnt_d;
  logic [1:0]            axis_q, axis_d;
  logic                  relay_q, relay_d;
  logic                  pwr_q, pwr_d;
  logic [3:0]            amp_q, amp_d;
  logic [1:0]            err_q, err_d;

  logic                  mv_lost, wdog_hit, stop_hit, safety_live;

  // tick is high for the one cycle in which the prescaler sits at zero after a wrap
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      prescale_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      prescale_q <= prescale_q + {{(PRESCALE_W-1){1'b0}}, 1'b1};
      tick_q     <= (prescale_q == {PRESCALE_W{1'b1}});
    end
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mv_cnt_q <= '0;
      axis_q   <= '0;
      relay_q  <= 1'b0;
      pwr_q    <= 1'b0;
      amp_q    <= 4'hf;
      err_q    <= ERR_NONE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mv_cnt_q <= mv_cnt_d;
      axis_q   <= axis_d;
      relay_q  <= relay_d;
      pwr_q    <= pwr_d;
      amp_q    <= amp_d;
      err_q    <= err_d;
    end
  end

  assign cnt_inc = cnt_q + 16'd1;

  assign mv_lost  = !bus.mv_good &&
                    ((state_q == SETTLE) || (state_q == ENABLE) || (state_q == RUN));
  assign wdog_hit = bus.wdog_timeout && ((state_q == ENABLE) || (state_q == RUN));
  assign stop_hit = bus.stop &&
                    ((state_q == RELAY) || (state_q == WAIT_MV) || (state_q == SETTLE) ||
                     (state_q == ENABLE) || (state_q == RUN));

  always_comb begin
    state_d  = state_q;
    cnt_d    = tick_q ? cnt_inc : cnt_q;
    mv_cnt_d = mv_cnt_q;
    axis_d   = axis_q;
    relay_d  = relay_q;
    pwr_d    = pwr_q;
    amp_d    = amp_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        relay_d = 1'b0;
        pwr_d   = 1'b0;
        amp_d   = 4'hf;
        if (bus.start && !bus.stop) begin
          state_d = RELAY;
          relay_d = 1'b1;
        end
      end

      RELAY: begin
        if (tick_q && (cnt_inc == RELAY_TC)) begin
          state_d = WAIT_MV;
          pwr_d   = 1'b1;
        end
      end

      WAIT_MV: begin
        if (tick_q) begin
          if (bus.mv_good) begin
            mv_cnt_d = mv_cnt_q + 3'd1;
          end else begin
            mv_cnt_d = 3'd0;
          end
          // a full run of good samples wins over a timeout landing on the same tick
          if (bus.mv_good && (mv_cnt_q == 3'd7)) begin
            state_d = SETTLE;
          end else if (cnt_inc == MV_TC) begin
            state_d = FAULT;
            relay_d = 1'b0;
            pwr_d   = 1'b0;
            amp_d   = 4'hf;
            err_d   = ERR_MV_TO;
          end
        end
      end

      SETTLE: begin
        if (tick_q && (cnt_inc == SETTLE_TC)) begin
          state_d = ENABLE;
        end
      end

      ENABLE: begin
        if (tick_q && (cnt_inc == STAGGER_TC)) begin
          cnt_d         = '0;
          amp_d[axis_q] = ~bus.axis_req[axis_q];
          axis_d        = axis_q + 2'd1;
          if (axis_q == 2'd3) begin
            state_d = RUN;
          end
        end
      end

      RUN: begin
        amp_d = ~bus.axis_req;
      end

      SHDN: begin
        amp_d = 4'hf;
        if (tick_q && (cnt_inc == STAGGER_TC)) begin
          pwr_d = 1'b0;
        end
        if (tick_q && (cnt_inc == SHDN_END_TC)) begin
          state_d = IDLE;
          relay_d = 1'b0;
          pwr_d   = 1'b0;
        end
      end

      FAULT: begin
        relay_d = 1'b0;
        pwr_d   = 1'b0;
        amp_d   = 4'hf;
        if (bus.clear) begin
          state_d = IDLE;
          err_d   = ERR_NONE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // faults outrank a shutdown request, and both outrank normal sequencing
    if (mv_lost || wdog_hit) begin
      state_d = FAULT;
      relay_d = 1'b0;
      pwr_d   = 1'b0;
      amp_d   = 4'hf;
      err_d   = mv_lost ? ERR_MV_LOST : ERR_WDOG;
    end else if (stop_hit) begin
      state_d = SHDN;
      amp_d   = 4'hf;
    end

    if (state_d != state_q) begin
      cnt_d    = '0;
      mv_cnt_d = '0;
      axis_d   = '0;
    end
  end

  assign safety_live = (state_q == ENABLE) || (state_q == RUN);

  assign bus.relay_on    = relay_q;
  assign bus.pwr_enable  = pwr_q;
  assign bus.amp_disable = amp_q | (bus.safety_amp_disable & {4{safety_live}});
  assign bus.state       = state_q;
  assign bus.err_code    = err_q;

endmodule

// File: tb/tb_pwr_sequencer.sv
// Directed bench for pwr_sequencer with short delays; timing is checked as edge-count
// differences between tick-aligned events, so prescaler phase does not matter.
module tb_pwr_sequencer;

  logic        sysclk;
  logic        reset;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  pwr_sequencer_if bus();

  pwr_sequencer #(
    .PRESCALE_W    (2),
    .RELAY_TICKS   (2),
    .MV_TIMEOUT    (20),
    .SETTLE_TICKS  (10),
    .STAGGER_TICKS (2)
  ) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse(input logic s, input logic p, input logic c);
    bus.start = s;
    bus.stop  = p;
    bus.clear = c;
    @(negedge sysclk);
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.clear = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag,
                            output int unsigned t);
    int n = 0;
    while (bus.state !== s && n < budget) begin
      @(negedge sysclk);
      n++;
    end
    t = cyc;
    check(tag, bus.state, s);
  endtask

  task automatic power_up(input string tag);
    int unsigned t;
    bus.mv_good = 1'b1;
    pulse(1'b1, 1'b0, 1'b0);
    wait_state(3'd5, 400, tag, t);
  endtask

  initial begin
    int unsigned t1, t2, t3, t4, t5, ts, tp, tr;
    int n;

    reset = 1'b0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.clear = 1'b0;
    bus.axis_req = 4'b1011;
    bus.mv_good = 1'b1;
    bus.wdog_timeout = 1'b0;
    bus.safety_amp_disable = 4'h0;
    repeat (3) @(negedge sysclk);

    check("rst_state", bus.state, 3'd0);
    check("rst_relay", bus.relay_on, 1'b0);
    check("rst_pwr", bus.pwr_enable, 1'b0);
    check("rst_amp", bus.amp_disable, 4'hf);
    check("rst_err", bus.err_code, 2'b00);
    reset = 1'b1;
    repeat (2) @(negedge sysclk);

    // start and stop together in IDLE: stop wins, nothing happens
    pulse(1'b1, 1'b1, 1'b0);
    check("idle_start_stop", bus.state, 3'd0);

    // full power-up, axis_req = 1011
    pulse(1'b1, 1'b0, 1'b0);
    wait_state(3'd1, 4, "enter_relay", t1);
    check("relay_relay_on", bus.relay_on, 1'b1);
    check("relay_pwr_off", bus.pwr_enable, 1'b0);
    wait_state(3'd2, 20, "enter_wait_mv", t2);
    check("wait_mv_pwr", bus.pwr_enable, 1'b1);
    wait_state(3'd3, 60, "enter_settle", t3);
    check("mv_qualify_cycles", t3 - t2, 32);
    wait_state(3'd4, 80, "enter_enable", t4);
    check("settle_cycles", t4 - t3, 40);
    check("enable_amp0", bus.amp_disable, 4'b1111);
    repeat (8) @(negedge sysclk);
    check("enable_amp1", bus.amp_disable, 4'b1110);
    repeat (8) @(negedge sysclk);
    check("enable_amp2", bus.amp_disable, 4'b1100);
    check("enable_still", bus.state, 3'd4);
    repeat (8) @(negedge sysclk);
    check("enable_amp3", bus.amp_disable, 4'b1100);
    repeat (8) @(negedge sysclk);
    check("enable_amp4", bus.amp_disable, 4'b0100);
    check("run_reached", bus.state, 3'd5);
    check("run_relay", bus.relay_on, 1'b1);
    check("run_pwr", bus.pwr_enable, 1'b1);

    // RUN follows axis_req one cycle late; safety OR is immediate
    bus.axis_req = 4'hf;
    #1 check("run_amp_latency", bus.amp_disable, 4'b0100);
    @(negedge sysclk);
    check("run_amp_follow", bus.amp_disable, 4'b0000);
    bus.safety_amp_disable = 4'b0100;
    #1 check("safety_or", bus.amp_disable, 4'b0100);
    check("safety_state", bus.state, 3'd5);
    bus.safety_amp_disable = 4'h0;
    #1 check("safety_release", bus.amp_disable, 4'b0000);
    @(negedge sysclk);

    // stop and start together in RUN -> orderly shutdown
    pulse(1'b1, 1'b1, 1'b0);
    ts = cyc;
    check("shdn_state", bus.state, 3'd6);
    check("shdn_amp", bus.amp_disable, 4'hf);
    check("shdn_pwr_held", bus.pwr_enable, 1'b1);
    n = 0;
    while (bus.pwr_enable !== 1'b0 && n < 40) begin
      @(negedge sysclk);
      n++;
    end
    tp = cyc;
    check("shdn_pwr_window", ((tp - ts) >= 5) && ((tp - ts) <= 8), 1'b1);
    check("shdn_relay_held", bus.relay_on, 1'b1);
    n = 0;
    while (bus.relay_on !== 1'b0 && n < 40) begin
      @(negedge sysclk);
      n++;
    end
    tr = cyc;
    check("shdn_relay_delay", tr - tp, 8);
    check("shdn_to_idle", bus.state, 3'd0);

    // mv_good never arrives -> timeout fault after 20 ticks in WAIT_MV
    bus.mv_good = 1'b0;
    pulse(1'b1, 1'b0, 1'b0);
    wait_state(3'd2, 20, "to_wait_mv", t2);
    wait_state(3'd7, 120, "mv_timeout_fault", t5);
    check("mv_timeout_cycles", t5 - t2, 80);
    check("mv_timeout_err", bus.err_code, 2'b01);
    check("fault_relay", bus.relay_on, 1'b0);
    check("fault_pwr", bus.pwr_enable, 1'b0);
    check("fault_amp", bus.amp_disable, 4'hf);
    pulse(1'b1, 1'b0, 1'b0);
    check("fault_ignore_start", bus.state, 3'd7);
    pulse(1'b0, 1'b1, 1'b0);
    check("fault_ignore_stop", bus.state, 3'd7);
    pulse(1'b0, 1'b0, 1'b1);
    check("clear_idle", bus.state, 3'd0);
    check("clear_err", bus.err_code, 2'b00);

    // mv loss and watchdog on the same cycle: mv loss wins
    bus.axis_req = 4'b1011;
    power_up("run_for_mv_loss");
    bus.mv_good = 1'b0;
    bus.wdog_timeout = 1'b1;
    @(negedge sysclk);
    check("mvlost_state", bus.state, 3'd7);
    check("mvlost_err", bus.err_code, 2'b10);
    check("mvlost_pwr", bus.pwr_enable, 1'b0);
    check("mvlost_amp", bus.amp_disable, 4'hf);
    bus.wdog_timeout = 1'b0;
    pulse(1'b0, 1'b0, 1'b1);
    check("mvlost_clear", bus.err_code, 2'b00);

    // watchdog alone
    power_up("run_for_wdog");
    bus.wdog_timeout = 1'b1;
    @(negedge sysclk);
    bus.wdog_timeout = 1'b0;
    check("wdog_state", bus.state, 3'd7);
    check("wdog_err", bus.err_code, 2'b11);
    pulse(1'b0, 1'b0, 1'b1);
    check("wdog_clear", bus.state, 3'd0);

    // asynchronous reset mid-SETTLE, then a fresh full sequence
    bus.mv_good = 1'b1;
    pulse(1'b1, 1'b0, 1'b0);
    wait_state(3'd3, 120, "to_settle", t3);
    #2 reset = 1'b0;
    #1 check("arst_state", bus.state, 3'd0);
    check("arst_relay", bus.relay_on, 1'b0);
    check("arst_pwr", bus.pwr_enable, 1'b0);
    check("arst_amp", bus.amp_disable, 4'hf);
    @(negedge sysclk);
    reset = 1'b1;
    @(negedge sysclk);
    power_up("rerun_after_reset");
    check("rerun_amp", bus.amp_disable, 4'b0100);
    check("rerun_relay", bus.relay_on, 1'b1);
    check("rerun_pwr", bus.pwr_enable, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
